// File: rtl/ps2_pkg.sv
// ps2_pkg: key codes, scan codes and state encodings shared by the PS/2 key decoder.
package ps2_pkg;
  localparam logic [3:0] KEY_NONE  = 4'b0000;
  localparam logic [3:0] KEY_A     = 4'b0001;
  localparam logic [3:0] KEY_D     = 4'b0010;
  localparam logic [3:0] KEY_S     = 4'b0011;
  localparam logic [3:0] KEY_W     = 4'b0100;
  localparam logic [3:0] KEY_SPACE = 4'b0101;
  localparam logic [7:0] SC_W      = 8'h1D;
  localparam logic [7:0] SC_S      = 8'h1B;
  localparam logic [7:0] SC_A      = 8'h1C;
  localparam logic [7:0] SC_D      = 8'h23;
  localparam logic [7:0] SC_SPACE  = 8'h29;
  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} rx_state_e;
  typedef enum logic [1:0] {BASE, BRK, EXT, EXT_BRK} dec_state_e;
  function automatic logic [3:0] key_of(input logic [7:0] sc);
    return sc == SC_W ? KEY_W : sc == SC_S ? KEY_S : sc == SC_A ? KEY_A :
           sc == SC_D ? KEY_D : sc == SC_SPACE ? KEY_SPACE : KEY_NONE;
  endfunction
endpackage

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: synchronises the PS/2 pins and assembles 11-bit frames into checked bytes.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_error
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  // clk_sync_q[2] holds the previous synchronised value for edge detection
  logic [2:0] clk_sync_q, clk_sync_d;
  logic [1:0] dat_sync_q, dat_sync_d;
  rx_state_e state_q, state_d;
  logic [9:0] sr_q, sr_d;
  logic [3:0] cnt_q, cnt_d;
  logic [CW-1:0] idle_q, idle_d;
  logic fall, dat, timeout;
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      state_q    <= IDLE;
      sr_q       <= '0;
      cnt_q      <= '0;
      idle_q     <= '0;
    end else begin
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      state_q    <= state_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      idle_q     <= idle_d;
    end
  end
  assign fall    = !clk_sync_q[1] && clk_sync_q[2];
  assign dat     = dat_sync_q[1];
  assign timeout = idle_q == CW'(TIMEOUT_CYCLES);
  assign rx_byte = sr_q[7:0];
  always_comb begin
    clk_sync_d  = {clk_sync_q[1:0], ps2_clk};
    dat_sync_d  = {dat_sync_q[0], ps2_dat};
    state_d     = state_q;
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    byte_valid  = 1'b0;
    frame_error = 1'b0;
    idle_d      = fall ? '0 : timeout ? idle_q : idle_q + 1'b1;
    if (state_q == IDLE && fall && !dat) begin
      state_d = SHIFT;
      cnt_d   = '0;
    end else if (state_q == SHIFT && fall) begin
      sr_d    = {dat, sr_q[9:1]};
      cnt_d   = cnt_q + 1'b1;
      state_d = cnt_q == 4'd9 ? CHECK : SHIFT;
    end else if (state_q == SHIFT && timeout) begin
      frame_error = 1'b1;
      state_d     = IDLE;
    end else if (state_q == CHECK) begin
      byte_valid  = ^sr_q[8:0] && sr_q[9];
      frame_error = !byte_valid;
      state_d     = IDLE;
    end
  end
endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: turns PS/2 set-2 make/break sequences for W/A/S/D/Space into key_press.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [3:0] key_press,
  output logic       key_event,
  output logic       frame_error,
  output logic [7:0] scan_code
);
  logic [7:0] rx_byte;
  logic byte_valid;
  logic [3:0] mapped;
  dec_state_e dec_q, dec_d;
  logic [3:0] key_q, key_d;
  logic [7:0] sc_q, sc_d;
  logic event_q, event_d;
  ps2_frame_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .clk        (CLOCK_50),
    .rst        (reset),
    .ps2_clk    (PS2_CLK),
    .ps2_dat    (PS2_DAT),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .frame_error(frame_error)
  );
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      dec_q   <= BASE;
      key_q   <= KEY_NONE;
      sc_q    <= '0;
      event_q <= 1'b0;
    end else begin
      dec_q   <= dec_d;
      key_q   <= key_d;
      sc_q    <= sc_d;
      event_q <= event_d;
    end
  end
  always_comb begin
    mapped = key_of(rx_byte);
    dec_d  = dec_q;
    key_d  = key_q;
    sc_d   = sc_q;
    if (byte_valid) begin
      sc_d = rx_byte;
      case (dec_q)
        BASE: begin
          dec_d = rx_byte == SC_BREAK ? BRK : rx_byte == SC_EXT ? EXT : BASE;
          key_d = mapped != KEY_NONE ? mapped : key_q;
        end
        // only releasing the key currently held clears it
        BRK: begin
          dec_d = BASE;
          key_d = (mapped != KEY_NONE && mapped == key_q) ? KEY_NONE : key_q;
        end
        EXT:     dec_d = rx_byte == SC_BREAK ? EXT_BRK : BASE;
        default: dec_d = BASE;
      endcase
    end
    event_d = key_d != key_q;
  end
  assign key_press = key_q;
  assign key_event = event_q;
  assign scan_code = sc_q;
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: PS/2 keyboard driver with a sequence-level key model checked every cycle.
module tb_ps2_key_decoder;
  localparam int TO = 200;
  localparam int H  = 4;
  logic CLOCK_50 = 1'b0, reset = 1'b1, PS2_CLK = 1'b1, PS2_DAT = 1'b1;
  logic [3:0] key_press;
  logic key_event, frame_error;
  logic [7:0] scan_code;
  ps2_key_decoder #(.TIMEOUT_CYCLES(TO)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .PS2_CLK(PS2_CLK), .PS2_DAT(PS2_DAT),
    .key_press(key_press), .key_event(key_event), .frame_error(frame_error), .scan_code(scan_code)
  );
  always #10 CLOCK_50 = ~CLOCK_50;
  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;
  int errors = 0, checks = 0;
  logic [3:0] cur_key = 4'h0, pend_key;
  logic [7:0] cur_sc = 8'h00, pend_sc;
  bit pend = 0, pend_chg;
  int pend_at, err_at = -1;
  logic [7:0] toks[$];
  int ev_cnt = 0, err_cnt = 0;
  function automatic logic [3:0] map(input logic [7:0] b);
    case (b)
      8'h1D:   return 4'h4;
      8'h1B:   return 4'h3;
      8'h1C:   return 4'h1;
      8'h23:   return 4'h2;
      8'h29:   return 4'h5;
      default: return 4'h0;
    endcase
  endfunction
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, got, exp, cyc);
    end
  endtask
  // Sequence-level parse: [x] make, [F0 x] break, [E0 x] / [E0 F0 x] ignored.
  task automatic model_byte(input logic [7:0] b, input int t);
    logic [3:0] nk;
    nk = cur_key;
    pend = 1; pend_at = t + 4; pend_sc = b;
    toks.push_back(b);
    if (!(toks.size() == 1 && (b == 8'hF0 || b == 8'hE0)) &&
        !(toks.size() == 2 && toks[0] == 8'hE0 && b == 8'hF0)) begin
      if (toks.size() == 1) nk = map(b) != 0 ? map(b) : cur_key;
      else if (toks[0] == 8'hF0 && map(b) != 0 && map(b) == cur_key) nk = 4'h0;
      toks.delete();
    end
    pend_key = nk;
    pend_chg = nk != cur_key;
  endtask
  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
    logic p;
    logic [10:0] f;
    p = ~^d ^ bad_par;
    f = {~bad_stop, p, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      @(negedge CLOCK_50); PS2_DAT = f[i];
      repeat (H) @(negedge CLOCK_50);
      PS2_CLK = 1'b0;
      if (i == 10) begin
        if (($countones({p, d}) % 2 == 1) && !bad_stop) model_byte(d, cyc);
        else err_at = cyc + 3;
      end
      repeat (H) @(negedge CLOCK_50);
      PS2_CLK = 1'b1;
    end
    repeat (H + 2) @(negedge CLOCK_50);
    PS2_DAT = 1'b1;
  endtask
  task automatic send_partial(input int n, input bit wait_to);
    for (int i = 0; i < n; i++) begin
      @(negedge CLOCK_50); PS2_DAT = i == 0 ? 1'b0 : 1'($urandom_range(0, 1));
      repeat (H) @(negedge CLOCK_50);
      PS2_CLK = 1'b0;
      if (i == n - 1 && wait_to) err_at = cyc + 3 + TO;
      repeat (H) @(negedge CLOCK_50);
      PS2_CLK = 1'b1;
    end
    @(negedge CLOCK_50); PS2_DAT = 1'b1;
    if (wait_to) repeat (TO + 20) @(negedge CLOCK_50);
  endtask
  task automatic do_reset();
    @(negedge CLOCK_50);
    reset = 1'b1;
    cur_key = 4'h0; cur_sc = 8'h00; pend = 0; err_at = -1; toks.delete();
    repeat (3) @(negedge CLOCK_50);
    reset = 1'b0;
  endtask
  always @(negedge CLOCK_50) begin
    bit ev_exp;
    if (!reset) begin
      ev_exp = 0;
      if (pend && cyc == pend_at) begin
        cur_key = pend_key; cur_sc = pend_sc; ev_exp = pend_chg; pend = 0;
      end
      if (key_event) ev_cnt++;
      if (frame_error) err_cnt++;
      chk("key_press", 32'(key_press), 32'(cur_key));
      chk("key_event", 32'(key_event), 32'(ev_exp));
      chk("frame_error", 32'(frame_error), 32'(cyc == err_at));
      chk("scan_code", 32'(scan_code), 32'(cur_sc));
    end
  end
  initial begin
    repeat (4) @(negedge CLOCK_50);
    reset = 1'b0;
    @(negedge CLOCK_50);
    chk("rst_key", 32'(key_press), 0);
    chk("rst_sc", 32'(scan_code), 0);
    send_frame(8'h1D, 0, 0);
    chk("w_key", 32'(key_press), 4);
    chk("w_sc", 32'(scan_code), 32'h1D);
    chk("w_events", ev_cnt, 1);
    send_frame(8'hF0, 0, 0); send_frame(8'h1D, 0, 0);
    chk("w_rel_key", 32'(key_press), 0);
    chk("w_rel_events", ev_cnt, 2);
    send_frame(8'h1D, 0, 0); send_frame(8'h23, 0, 0);
    chk("d_key", 32'(key_press), 2);
    send_frame(8'hF0, 0, 0); send_frame(8'h1D, 0, 0);
    chk("d_keep_key", 32'(key_press), 2);
    send_frame(8'hF0, 0, 0); send_frame(8'h23, 0, 0);
    chk("d_rel_key", 32'(key_press), 0);
    chk("wd_events", ev_cnt, 5);
    send_frame(8'h1D, 1, 0);
    chk("par_err", err_cnt, 1);
    send_frame(8'h1D, 0, 1);
    chk("stop_err", err_cnt, 2);
    chk("err_key", 32'(key_press), 0);
    chk("err_sc", 32'(scan_code), 32'h23);
    send_frame(8'hE0, 0, 0); send_frame(8'h1D, 0, 0);
    send_frame(8'hE0, 0, 0); send_frame(8'hF0, 0, 0); send_frame(8'h1D, 0, 0);
    chk("ext_key", 32'(key_press), 0);
    chk("ext_events", ev_cnt, 5);
    chk("ext_errs", err_cnt, 2);
    send_partial(5, 1);
    chk("timeout_err", err_cnt, 3);
    send_frame(8'h29, 0, 0);
    chk("space_key", 32'(key_press), 5);
    send_partial(4, 0);
    do_reset();
    repeat (2) @(negedge CLOCK_50);
    chk("midrst_key", 32'(key_press), 0);
    chk("midrst_errs", err_cnt, 3);
    send_frame(8'h1C, 0, 0);
    chk("a_key", 32'(key_press), 1);
    for (int n = 0; n < 220; n++) begin
      int r;
      logic [7:0] b;
      r = $urandom_range(0, 99);
      case ($urandom_range(0, 9))
        0: b = 8'h1D; 1: b = 8'h1B; 2: b = 8'h1C; 3: b = 8'h23; 4: b = 8'h29;
        5, 6: b = 8'hF0; 7: b = 8'hE0;
        default: b = 8'($urandom);
      endcase
      if (r < 3) send_partial($urandom_range(1, 10), 1);
      else if (r < 5) begin send_partial($urandom_range(1, 10), 0); do_reset(); end
      else send_frame(b, r < 12, r >= 12 && r < 16);
      repeat ($urandom_range(0, 20)) @(negedge CLOCK_50);
    end
    repeat (10) @(negedge CLOCK_50);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
